// File: rtl/mips_fetch_pkg.sv
// mips_fetch_pkg: shared fetch constants, queue entry type and PC helpers
package mips_fetch_pkg;
    localparam logic [31:0] MIPS_NOP = 32'h0;
    typedef struct packed {
        logic [31:0] op;
        logic [31:0] next;
    } fetch_entry_t;
    function automatic logic [31:0] word_align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction
    function automatic logic [31:0] pc_inc(input logic [31:0] a);
        return a + 32'd4;
    endfunction
endpackage

// File: rtl/mips_fetch_if.sv
// mips_fetch_if: code-memory request channel plus ID/RF and EX redirect signals
interface mips_fetch_if;
    logic [31:0] pc;
    logic        req;
    logic        ack;
    logic [31:0] op;
    logic        opv;
    logic [31:0] ro;
    logic [31:0] rn;
    logic        rv;
    logic        stall;
    logic        fv;
    logic [31:0] fa;
    modport master (output pc, req, ro, rn, rv, input ack, op, opv, stall, fv, fa);
    modport slave  (input pc, req, ro, rn, rv, output ack, op, opv, stall, fv, fa);
endinterface

// File: rtl/mips_fetch_fifo.sv
// mips_fetch_fifo: synchronous prefetch queue with push, pop, clear and occupancy count
module mips_fetch_fifo #(
    parameter int W     = 64,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic          clear,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  dout,
    output logic [CW-1:0] count
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wp, rp;
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else if (clear) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            wp    <= push ? wp + 1'b1 : wp;
            rp    <= pop ? rp + 1'b1 : rp;
            count <= count + CW'(push) - CW'(pop);
        end
    end
    always_ff @(posedge clock) begin
        if (push && !clear) mem[wp] <= din;
    end
    assign dout = mem[rp];
endmodule

// File: rtl/mips_fetch.sv
// mips_fetch: credit-based prefetching MIPS fetch stage with redirect flush and ID stall
module mips_fetch
    import mips_fetch_pkg::*;
#(
    parameter logic [31:0] START = 32'h0,
    parameter int          DEPTH = 4,
    parameter logic [31:0] NOP   = MIPS_NOP
) (
    input logic             clock,
    input logic             reset,
    mips_fetch_if.master    bus
);
    localparam int CW = $clog2(DEPTH + 1);
    logic [CW-1:0] cnt, out, disc;
    logic [CW:0]   occ;
    logic [31:0]   pc, ro, rn;
    logic          rv, acc, resp, push, pop;
    fetch_entry_t  head, tail;
    assign occ  = (CW+1)'(cnt) + (CW+1)'(out);
    assign acc  = bus.req && bus.ack;
    assign resp = bus.opv && out != '0;
    assign push = resp && disc == '0 && !bus.fv;
    assign pop  = !bus.fv && !bus.stall && cnt != '0;
    // Every live in-flight request is contiguous and ends just below pc.
    assign tail = '{op: bus.op, next: pc_inc(pc - (32'(out) << 2))};
    assign bus.req = !bus.fv && occ < (CW+1)'(DEPTH);
    assign bus.pc  = pc;
    assign bus.ro  = ro;
    assign bus.rn  = rn;
    assign bus.rv  = rv;
    mips_fetch_fifo #(.W(64), .DEPTH(DEPTH)) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .clear (bus.fv),
        .din   (tail),
        .dout  (head),
        .count (cnt)
    );
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc   <= START;
            out  <= '0;
            disc <= '0;
            ro   <= NOP;
            rn   <= '0;
            rv   <= 1'b0;
        end else begin
            out <= out + CW'(acc) - CW'(resp);
            if (bus.fv) begin
                pc   <= word_align(bus.fa);
                disc <= out - CW'(resp);
                ro   <= NOP;
                rv   <= 1'b0;
            end else begin
                pc   <= acc ? pc_inc(pc) : pc;
                disc <= (resp && disc != '0) ? disc - 1'b1 : disc;
                ro   <= bus.stall ? ro : (pop ? head.op : NOP);
                rn   <= (bus.stall || !pop) ? rn : head.next;
                rv   <= bus.stall ? rv : pop;
            end
        end
    end
endmodule
